key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of independent key channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the consecutive stable synchronized samples required to accept a change; legal range 2..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port raw, input, WIDTH bits: asynchronous, bouncing key levels from board pins.
REQ-006 The block SHALL have port out, output, WIDTH bits: debounced active-high level per key, registered, feeding the downstream one-pulse edge stage's press input.
REQ-007 The block SHALL have port settling, output, WIDTH bits: per-key flag, 1 while that channel is confirming a candidate change.

Function
REQ-008 Each raw bit SHALL pass through a 2-flop synchronizer; the second flop's output s[i] is the only value used by channel i's logic.
REQ-009 Each channel SHALL run an independent 4-state FSM: LOW, CHK_HI, HIGH, CHK_LO; out[i]=1 in HIGH and CHK_LO, 0 in LOW and CHK_HI; settling[i]=1 only in CHK_HI or CHK_LO.
REQ-010 LOW: s=1 -> CHK_HI with cnt=1; s=0 -> stay.
REQ-011 CHK_HI: s=0 -> LOW, cnt=0 (abort, out never asserted); s=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, cnt=0; s=1 otherwise -> cnt+1.
REQ-012 HIGH and CHK_LO SHALL mirror REQ-010/011 with levels inverted (HIGH -> CHK_LO on s=0; abort returns to HIGH).
REQ-013 Latency: for a clean raw change between edges, out SHALL change on the (DEBOUNCE_CYCLES+2)th following rising edge.
REQ-014 Any glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no change on out.
REQ-015 Each per-channel counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide, unsigned, and never wrap: it is cleared on every state exit.
REQ-016 Channels SHALL be fully independent; simultaneous changes on several bits SHALL each complete with identical latency.
REQ-017 out and settling SHALL be driven directly from state registers, with no combinational path from raw.

Reset
REQ-018 While reset=1 at a rising edge, all FSMs SHALL go to LOW, all counters to 0, all synchronizer flops to 0; out=0 and settling=0 after that edge.
REQ-019 Reset asserted mid-confirmation SHALL discard the candidate; after release, a key still held SHALL require the full REQ-013 latency before out rises.

Configuration
REQ-020 Macro KEY_DEBOUNCER_ACTIVE_LOW_EN defined: raw SHALL be inverted before the first synchronizer flop (pressed KEY pin = 0 gives out=1); synchronizer reset value remains 0 on the inverted path, so an idle (1) pin gives no false press.
REQ-021 Macro undefined: raw SHALL be used non-inverted (1 = pressed); all other behaviour identical.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, macro undefined unless stated)
REQ-022 Reset 1 cycle, raw=0000 held 10 cycles -> out=0000, settling=0000 throughout.
REQ-023 raw[0] 0->1 and held -> settling[0]=1 from edge 3 through edge 5, out[0]=1 exactly at edge 6, out[0] stays 1.
REQ-024 raw[1] toggled 1,0,1,0 every cycle then held 0 -> out[1]=0 throughout, settling[1] pulses but returns 0.
REQ-025 raw[2] high 3 cycles then low -> out[2] never asserts; raw[2] high 4 cycles -> out[2] asserts, then deasserts 6 edges after raw falls.
REQ-026 raw=1111 held, reset pulsed at edge 4 -> out=0000 after reset, out=1111 at the 6th edge after reset release.
REQ-027 Macro defined, raw=1111 (idle) after reset -> out=0000; raw[3]=0 held -> out[3]=1 at edge 6.

Source files
------------

// File: rtl/key_debouncer.sv
// key_debouncer: per-key 2-flop synchronizer plus 4-state confirm FSM producing debounced levels.
// Define KEY_DEBOUNCER_ACTIVE_LOW_EN for active-low key pins (inverted before the synchronizer).
module key_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] settling
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} state_t;

    logic [WIDTH-1:0] pin_lvl;
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

`ifdef KEY_DEBOUNCER_ACTIVE_LOW_EN
    assign pin_lvl = ~raw;
`else
    assign pin_lvl = raw;
`endif

    // two-flop synchronizer; resets to 0 on the (possibly inverted) pressed-level path
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= pin_lvl;
            sync_q <= meta_q;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        state_t        state_q;
        logic [CW-1:0] cnt_q;
        logic          out_q;
        logic          settling_q;

        // confirm FSM: a candidate level must be seen DEBOUNCE_CYCLES samples in a row
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q    <= LOW;
                cnt_q      <= '0;
                out_q      <= 1'b0;
                settling_q <= 1'b0;
            end else begin
                unique case (state_q)
                    LOW: if (sync_q[g]) begin
                        state_q    <= CHK_HI;
                        cnt_q      <= CW'(1);
                        settling_q <= 1'b1;
                    end
                    CHK_HI: if (!sync_q[g]) begin
                        state_q    <= LOW;
                        cnt_q      <= '0;
                        settling_q <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= HIGH;
                        cnt_q      <= '0;
                        out_q      <= 1'b1;
                        settling_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    HIGH: if (!sync_q[g]) begin
                        state_q    <= CHK_LO;
                        cnt_q      <= CW'(1);
                        settling_q <= 1'b1;
                    end
                    CHK_LO: if (sync_q[g]) begin
                        state_q    <= HIGH;
                        cnt_q      <= '0;
                        settling_q <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= LOW;
                        cnt_q      <= '0;
                        out_q      <= 1'b0;
                        settling_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    default: begin
                        state_q    <= LOW;
                        cnt_q      <= '0;
                        out_q      <= 1'b0;
                        settling_q <= 1'b0;
                    end
                endcase
            end
        end

        assign out[g]      = out_q;
        assign settling[g] = settling_q;
    end
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed and random stimulus against a run-length model via a scoreboard queue.
module tb_key_debouncer;
    localparam int W = 4;
    localparam int D = 4;
`ifdef KEY_DEBOUNCER_ACTIVE_LOW_EN
    localparam logic [W-1:0] INV = '1;
`else
    localparam logic [W-1:0] INV = '0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] raw = INV;
    logic [W-1:0] out;
    logic [W-1:0] settling;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m1 = '0, m2 = '0, mo = '0, ms = '0;
    int           run [W];
    logic [2*W-1:0] sb [$];
    logic [2*W-1:0] got;

    key_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .raw(raw), .out(out), .settling(settling)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive pressed levels p for one cycle; the model counts consecutive synchronized samples
    // that disagree with the debounced level and flips once D of them are seen
    task automatic step(input logic [W-1:0] p, input logic rst);
        raw   = p ^ INV;
        reset = rst;
        @(posedge clk);
        if (rst) begin
            m1 = '0; m2 = '0; mo = '0; ms = '0;
            for (int c = 0; c < W; c++) run[c] = 0;
        end else begin
            for (int c = 0; c < W; c++) begin
                run[c] = (m2[c] != mo[c]) ? run[c] + 1 : 0;
                if (run[c] == D) begin
                    mo[c]  = ~mo[c];
                    run[c] = 0;
                end
                ms[c] = (run[c] > 0);
            end
            m2 = m1;
            m1 = p;
        end
        sb.push_back({mo, ms});
        #1;
        got = {out, settling};
        if (sb.size() == 0) chk("scoreboard_empty", 8'h01, 8'h00);
        else chk("scoreboard", got, sb.pop_front());
    endtask

    initial begin
        for (int c = 0; c < W; c++) run[c] = 0;
        step(4'b0000, 1'b1);
        chk("reset_state", {out, settling}, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 1'b0);
            chk("idle_zero", {out, settling}, 8'h00);
        end
        for (int i = 1; i <= 8; i++) begin
            step(4'b0001, 1'b0);
            chk("press0_settling", {7'b0, settling[0]}, {7'b0, (i >= 3 && i <= 5)});
            chk("press0_out", {7'b0, out[0]}, {7'b0, (i >= 6)});
        end
        step(4'b0011, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0001, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(4'b0001, 1'b0);
            chk("toggle1_out", {7'b0, out[1]}, 8'h00);
        end
        chk("toggle1_settled", {7'b0, settling[1]}, 8'h00);
        for (int i = 0; i < 3; i++) step(4'b0101, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(4'b0001, 1'b0);
            chk("glitch2_out", {7'b0, out[2]}, 8'h00);
        end
        for (int i = 0; i < 4; i++) step(4'b0101, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0101, 1'b0);
        chk("hold2_out", {7'b0, out[2]}, 8'h01);
        for (int i = 1; i <= 8; i++) begin
            step(4'b0001, 1'b0);
            chk("release2_out", {7'b0, out[2]}, {7'b0, (i < 6)});
        end
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);
        chk("midreset_out", {out, settling}, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            step(4'b1111, 1'b0);
            chk("after_reset_out", {4'b0, out}, (i >= 6) ? 8'h0F : 8'h00);
        end
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) m1 = m1;
            step(($urandom_range(0, 3) == 0) ? 4'($urandom) : raw ^ INV, 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
